// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module mul_div_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic [31:0] quo, rem, div_mag;
  logic        neg_q, neg_r, div_zero;
  logic        done_q;

  logic        start_mul, start_div;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] rem_shift, rem_diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic        div_sgn, a_neg, b_neg;

  assign start_mul = start && (funct == F_MULT || funct == F_MULTU);
  assign start_div = start && (funct == F_DIV  || funct == F_DIVU);

  // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the product
  // are then correct for both signed and unsigned operands.
  always_comb begin
    ext_a   = op_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    ext_b   = op_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    product = ext_a * ext_b;
  end

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    rem_shift = {rem, quo[31]};
    rem_diff  = rem_shift - {1'b0, div_mag};
    q_bit     = ~rem_diff[32];
    rem_next  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
  end

  always_comb begin
    div_sgn = (funct == F_DIV);
    a_neg   = div_sgn & opA[31];
    b_neg   = div_sgn & opB[31];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_mul)      state_next = S_MUL;
        else if (start_div) state_next = (opB == 32'd0) ? S_FIX : S_DIV;
      end
      S_MUL:   if (cnt == 5'd0) state_next = S_IDLE;
      S_DIV:   if (cnt == 5'd0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= 32'd0;
      lo        <= 32'd0;
      done_q    <= 1'b0;
      cnt       <= 5'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      quo       <= 32'd0;
      rem       <= 32'd0;
      div_mag   <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (funct)
              F_MTHI: hi <= opA;
              F_MTLO: lo <= opA;
              F_MULT, F_MULTU: begin
                op_a      <= opA;
                op_b      <= opB;
                op_signed <= (funct == F_MULT);
                cnt       <= 5'(MUL_CYCLES - 1);
              end
              F_DIV, F_DIVU: begin
                op_a     <= opA;
                quo      <= a_neg ? -opA : opA;
                div_mag  <= b_neg ? -opB : opB;
                rem      <= 32'd0;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (opB == 32'd0);
                cnt      <= 5'(DIV_ITERS - 1);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt == 5'd0) begin
            {hi, lo} <= product;
            done_q   <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_DIV: begin
          rem <= rem_next;
          quo <= {quo[30:0], q_bit};
          cnt <= cnt - 5'd1;
        end
        S_FIX: begin
          // Truncating negation makes 0x80000000 / -1 come out as 0x80000000.
          if (div_zero) begin
            lo <= 32'hFFFF_FFFF;
            hi <= op_a;
          end else begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: reset, multiply, divide, special cases,
// MTHI/MTLO, ignored starts and back-to-back issue.
module tb_mul_div_unit;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.MUL_CYCLES(4), .DIV_ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .opA(opA), .opB(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the first negedge after the start edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct = f; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct = 6'd0; opA = 32'hDEAD_BEEF; opB = 32'h0BAD_F00D;
  endtask

  // Count busy cycles (including the current one) until busy drops; bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h exp 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int c;
    issue(F_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 4) begin n_err++; $display("FAIL mult_busy_cycles got %0d exp 4", c); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done got %b exp 1", done); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo got %h exp fffffffe", lo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_width got %b exp 0", done); end

    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 4) begin n_err++; $display("FAIL multu_busy_cycles got %0d exp 4", c); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL multu_done got %b exp 1", done); end
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL multu_hi got %h exp 1", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got %h exp fffffffe", lo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_width got %b exp 0", done); end
  endtask

  task automatic test_div;
    int c;
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 33) begin n_err++; $display("FAIL div_busy_cycles got %0d exp 33", c); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL div_done got %b exp 1", done); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h exp ffffffff", hi); end

    issue(F_DIVU, 32'd100, 32'd7);
    wait_idle(c);
    n_cmp++; if (c !== 33) begin n_err++; $display("FAIL divu_busy_cycles got %0d exp 33", c); end
    n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h exp e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h exp 2", hi); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL divu_done_width got %b exp 0", done); end
  endtask

  task automatic test_div_special;
    int c;
    issue(F_DIVU, 32'd7, 32'd0);
    wait_idle(c);
    n_cmp++; if (c !== 1) begin n_err++; $display("FAIL divzero_busy_cycles got %0d exp 1", c); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL divzero_done got %b exp 1", done); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divzero_lo got %h exp ffffffff", lo); end
    n_cmp++; if (hi !== 32'd7) begin n_err++; $display("FAIL divzero_hi got %h exp 7", hi); end

    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    n_cmp++; if (c !== 33) begin n_err++; $display("FAIL ovf_busy_cycles got %0d exp 33", c); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo got %h exp 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ovf_hi got %h exp 0", hi); end
  endtask

  task automatic test_mt_and_ignored;
    int c;
    issue(F_MTLO, 32'h1234, 32'd0);
    n_cmp++; if (lo !== 32'h1234) begin n_err++; $display("FAIL mtlo_lo got %h exp 1234", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mtlo_done got %b exp 0", done); end
    issue(F_MTHI, 32'h5678, 32'd0);
    n_cmp++; if (hi !== 32'h5678) begin n_err++; $display("FAIL mthi_hi got %h exp 5678", hi); end
    n_cmp++; if (lo !== 32'h1234) begin n_err++; $display("FAIL mthi_lo_kept got %h exp 1234", lo); end

    issue(F_ADD, 32'd9, 32'd9);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL badfunct_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL badfunct_done got %b exp 0", done); end
    n_cmp++; if (hi !== 32'h5678) begin n_err++; $display("FAIL badfunct_hi got %h exp 5678", hi); end
    n_cmp++; if (lo !== 32'h1234) begin n_err++; $display("FAIL badfunct_lo got %h exp 1234", lo); end

    // MULT 3*3 strobed mid-divide must be ignored.
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      c++;
      if (c == 5) begin
        start = 1'b1; funct = F_MULT; opA = 32'd3; opB = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++; if (c !== 33) begin n_err++; $display("FAIL intrude_busy_cycles got %0d exp 33", c); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL intrude_lo got %h exp fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL intrude_hi got %h exp ffffffff", hi); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL intrude_after_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_div;
    int n;
    bit seen;
    issue(F_DIVU, 32'd100, 32'd7);
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL middiv_busy got %b exp 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL middiv_reset_busy got %b exp 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL middiv_reset_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL middiv_reset_lo got %h exp 0", lo); end
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL middiv_no_done got %b exp 0", seen); end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(F_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(c);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b exp 1", done); end
    start = 1'b1; funct = F_MULTU; opA = 32'd3; opB = 32'd5;
    @(negedge clk);
    start = 1'b0; opA = 32'd0; opB = 32'd0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_low got %b exp 0", done); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_hi_hold got %h exp ffffffff", hi); end
    wait_idle(c);
    n_cmp++; if (c !== 4) begin n_err++; $display("FAIL b2b_busy_cycles got %0d exp 4", c); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_hi got %h exp 0", hi); end
    n_cmp++; if (lo !== 32'd15) begin n_err++; $display("FAIL b2b_lo got %h exp f", lo); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b exp 1", done); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_mt_and_ignored();
    test_reset_mid_div();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
